// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback for the
// datapath, waits on a variable-latency memory and guards each access with a timeout.
//
//  state     | meaning
//  S_RST     | held in reset, every output low
//  S_FETCH   | read instruction at PC, PC+4 on mem_ready
//  S_DECODE  | compute branch target, dispatch on opcode
//  S_MEMADR  | rs + imm for LW/SW
//  S_MEMRD   | data read at ALUOut
//  S_MEMWB   | MDR -> rt
//  S_MEMWR   | data write at ALUOut
//  S_EXEC    | R-type ALU operation
//  S_ALUWB   | ALUOut -> rd
//  S_BRANCH  | compare rs/rt, conditional PC load
//  S_ADDIEX  | rs + imm
//  S_ADDIWB  | ALUOut -> rt
//  S_JUMP    | PC <- jump target
module multicycle_control #(
    parameter int ALU_OP_W    = 4,
    parameter bit USE_MEM_RDY = 1'b1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_src,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                mem_err,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Down-counter loaded with MEM_TIMEOUT-1; reaching zero while still waiting is the timeout.
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_wait;

    state_t w_next;
    logic   w_ready;
    logic   w_in_mem;
    logic   w_timeout;
    logic   w_rtype_ok;
    logic   w_legal;
    logic   w_in_fetch;

    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        logic [3:0] op;
        op = ALU_ADD;
        case (fn)
            F_SUB:   op = ALU_SUB;
            F_AND:   op = ALU_AND;
            F_OR:    op = ALU_OR;
            F_SLT:   op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] fn);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (s)
            S_RST:    c.alu_op = '0;
            S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = funct_alu(fn); end
            S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'b01;
            end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP:   begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_ready    = USE_MEM_RDY ? mem_ready : 1'b1;
        w_in_fetch = (r_state == S_FETCH);
        w_in_mem   = w_in_fetch || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_timeout  = (MEM_TIMEOUT != 0) && w_in_mem && !w_ready && (r_wait == '0);
        w_rtype_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        w_legal    = (opcode inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J})
                     || ((opcode == OP_RTYPE) && w_rtype_ok);

        w_next = r_state;
        case (r_state)
            S_RST:   w_next = S_FETCH;
            S_FETCH: if (w_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = w_rtype_ok ? S_EXEC : S_FETCH;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (w_ready)        w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_MEMWR: if (w_ready || w_timeout) w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RST;
            r_ctrl  <= '0;
            r_wait  <= WAIT_LOAD;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next, funct);
            if (w_in_mem && !w_ready && !w_timeout && (r_wait != '0))
                r_wait <= r_wait - CNT_W'(1);
            else
                r_wait <= WAIT_LOAD;
        end
    end

    assign pc_write      = r_ctrl.pc_write | (w_in_fetch & w_ready);
    assign ir_write      = w_in_fetch & w_ready;
    assign pc_write_cond = r_ctrl.pc_write_cond;
    assign pc_src        = r_ctrl.pc_src;
    assign iord          = r_ctrl.iord;
    assign mem_read      = r_ctrl.mem_read;
    assign mem_write     = r_ctrl.mem_write;
    assign reg_dst       = r_ctrl.reg_dst;
    assign mem_to_reg    = r_ctrl.mem_to_reg;
    assign reg_write     = r_ctrl.reg_write;
    assign alu_src_a     = r_ctrl.alu_src_a;
    assign alu_src_b     = r_ctrl.alu_src_b;
    assign alu_op        = ALU_OP_W'(r_ctrl.alu_op);
    assign illegal       = (r_state == S_DECODE) && !w_legal;
    assign mem_err       = w_timeout;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: expected per-cycle control words come from
// an instruction-level model that expands each instruction into its sequence of steps.
module tb_multicycle_control;

    localparam int TO = 4;

    localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4;
    localparam int S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_ALUWB = 8, S_BRANCH = 9;
    localparam int S_ADDIEX = 10, S_ADDIWB = 11, S_JUMP = 12;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, mem_err;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op, state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int st;
        bit rdy;
        bit err;
    } ent_t;

    ent_t q[$];
    logic [5:0] funct_list[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    always #5 clk = ~clk;

    multicycle_control #(.ALU_OP_W(4), .USE_MEM_RDY(1'b1), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .mem_err(mem_err),
        .state(state)
    );

    function automatic bit rtype_ok(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        return (op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) || (op == OP_R && rtype_ok(fn));
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic ent_t mk(input int st, input bit rdy, input bit err);
        ent_t e;
        e.st = st; e.rdy = rdy; e.err = err;
        return e;
    endfunction

    // Expected control word for one step of an instruction.
    function automatic logic [23:0] exp_vec(input ent_t e, input logic [5:0] op, input logic [5:0] fn);
        logic pcw, pcc, io, mr, mw, irw, rd, m2r, rw, sa, ill, me;
        logic [1:0] ps, sb;
        logic [3:0] ao;
        {pcw, pcc, io, mr, mw, irw, rd, m2r, rw, sa, ill, me} = '0;
        ps = 2'b00; sb = 2'b00; ao = 4'b0010;
        case (e.st)
            S_RST:    ao = 4'b0000;
            S_FETCH:  begin mr = 1; sb = 2'b01; irw = e.rdy; pcw = e.rdy; me = e.err; end
            S_DECODE: begin sb = 2'b11; ill = !legal(op, fn); end
            S_MEMADR: begin sa = 1; sb = 2'b10; end
            S_MEMRD:  begin mr = 1; io = 1; me = e.err; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mw = 1; io = 1; me = e.err; end
            S_EXEC:   begin sa = 1; ao = alu_of(fn); end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_BRANCH: begin sa = 1; ao = 4'b0110; pcc = 1; ps = 2'b01; end
            S_ADDIEX: begin sa = 1; sb = 2'b10; end
            S_ADDIWB: rw = 1;
            S_JUMP:   begin pcw = 1; ps = 2'b10; end
            default:  ;
        endcase
        return {pcw, pcc, ps, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ill, me, 4'(e.st)};
    endfunction

    // Expand one instruction into its step sequence; wf/wm are not-ready cycles before the
    // fetch / data access completes. A wait of TO or more cycles times out.
    task automatic build_seq(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        int n;
        bit done;
        int mst;
        q.delete();
        n = wf;
        done = 0;
        while (!done) begin
            for (int c = 0; c < TO; c++) begin
                if (!done) begin
                    if (c >= n) begin q.push_back(mk(S_FETCH, 1, 0)); done = 1; end
                    else q.push_back(mk(S_FETCH, 0, c == TO - 1));
                end
            end
            n -= TO;
        end
        q.push_back(mk(S_DECODE, 1'($urandom), 0));
        if (op == OP_LW || op == OP_SW) begin
            q.push_back(mk(S_MEMADR, 1'($urandom), 0));
            mst = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            if (wm >= TO) begin
                for (int c = 0; c < TO; c++) q.push_back(mk(mst, 0, c == TO - 1));
            end else begin
                for (int c = 0; c < wm; c++) q.push_back(mk(mst, 0, 0));
                q.push_back(mk(mst, 1, 0));
                if (op == OP_LW) q.push_back(mk(S_MEMWB, 1'($urandom), 0));
            end
        end else if (op == OP_R && rtype_ok(fn)) begin
            q.push_back(mk(S_EXEC, 1'($urandom), 0));
            q.push_back(mk(S_ALUWB, 1'($urandom), 0));
        end else if (op == OP_BEQ) begin
            q.push_back(mk(S_BRANCH, 1'($urandom), 0));
        end else if (op == OP_ADDI) begin
            q.push_back(mk(S_ADDIEX, 1'($urandom), 0));
            q.push_back(mk(S_ADDIWB, 1'($urandom), 0));
        end else if (op == OP_J) begin
            q.push_back(mk(S_JUMP, 1'($urandom), 0));
        end
    endtask

    task automatic drive_sample(input bit rdy, output logic [23:0] obs);
        mem_ready = rdy;
        #1;
        obs = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, mem_err, state};
    endtask

    task automatic run_seq(input string tag, input logic [5:0] op, input logic [5:0] fn);
        logic [23:0] obs, exp;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin opcode = op; funct = fn; end
            drive_sample(q[i].rdy, obs);
            exp = exp_vec(q[i], op, fn);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s step %0d (op=%b fn=%b): got %h expected %h", tag, i, op, fn, obs, exp);
            end
        end
    endtask

    task automatic test_reset;
        logic [23:0] obs;
        rst_n = 0; opcode = 6'b100011; funct = 6'b100000; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1;
            drive_sample(1'($urandom), obs);
            checks++;
            if (obs !== exp_vec(mk(S_RST, 0, 0), opcode, funct)) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, obs, exp_vec(mk(S_RST, 0, 0), opcode, funct));
            end
        end
    endtask

    task automatic test_lw;
        build_seq(OP_LW, 6'($urandom), 0, 0);
        run_seq("lw_fast", OP_LW, funct);
        build_seq(OP_LW, 6'($urandom), 2, 1);
        run_seq("lw_wait", OP_LW, funct);
    endtask

    task automatic test_sw_wait;
        build_seq(OP_SW, 6'($urandom), 0, 2);
        run_seq("sw_wait2", OP_SW, funct);
    endtask

    task automatic test_rtype;
        foreach (funct_list[k]) begin
            build_seq(OP_R, funct_list[k], $urandom_range(0, 2), 0);
            run_seq("rtype", OP_R, funct_list[k]);
        end
    endtask

    task automatic test_other_ops;
        build_seq(OP_BEQ, 6'($urandom), 0, 0);  run_seq("beq", OP_BEQ, funct);
        build_seq(OP_ADDI, 6'($urandom), 1, 0); run_seq("addi", OP_ADDI, funct);
        build_seq(OP_J, 6'($urandom), 0, 0);    run_seq("jump", OP_J, funct);
    endtask

    task automatic test_illegal;
        build_seq(6'b111111, 6'b100000, 0, 0); run_seq("illegal_op", 6'b111111, 6'b100000);
        build_seq(OP_R, 6'b000001, 0, 0);      run_seq("illegal_funct", OP_R, 6'b000001);
    endtask

    task automatic test_timeout;
        build_seq(OP_J, 6'd0, TO, 0);          run_seq("fetch_timeout", OP_J, 6'd0);
        build_seq(OP_J, 6'd0, TO - 1, 0);      run_seq("fetch_last_cycle_ready", OP_J, 6'd0);
        build_seq(OP_LW, 6'd0, 0, TO);         run_seq("memrd_timeout", OP_LW, 6'd0);
        build_seq(OP_SW, 6'd0, 0, TO);         run_seq("memwr_timeout", OP_SW, 6'd0);
        build_seq(OP_SW, 6'd0, 0, TO - 1);     run_seq("memwr_last_cycle_ready", OP_SW, 6'd0);
        build_seq(OP_BEQ, 6'd0, 2 * TO + 1, 0); run_seq("fetch_double_timeout", OP_BEQ, 6'd0);
    endtask

    task automatic test_reset_midwait;
        logic [23:0] obs, exp;
        build_seq(OP_LW, 6'd0, 0, 3);
        while (q.size() > 5) void'(q.pop_back());
        run_seq("lw_pre_reset", OP_LW, 6'd0);
        @(negedge clk);
        rst_n = 0;
        drive_sample(0, obs);
        exp = exp_vec(mk(S_MEMRD, 0, 0), OP_LW, 6'd0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL midwait_before_reset: got %h expected %h", obs, exp); end
        @(negedge clk);
        rst_n = 1;
        drive_sample(1, obs);
        exp = exp_vec(mk(S_RST, 0, 0), OP_LW, 6'd0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL midwait_reset: got %h expected %h", obs, exp); end
        build_seq(OP_J, 6'd0, TO - 1, 0);
        run_seq("after_midwait_reset", OP_J, 6'd0);
    endtask

    task automatic test_back_to_back;
        logic [5:0] op, fn;
        int wf, wm;
        for (int n = 0; n < 40; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0: op = OP_LW;
                1: op = OP_SW;
                2: begin op = OP_R; fn = funct_list[$urandom_range(0, 4)]; end
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                6: begin op = 6'($urandom); while (legal(op, fn)) op = 6'($urandom); end
                default: begin op = OP_R; while (rtype_ok(fn)) fn = 6'($urandom); end
            endcase
            wf = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 6);
            wm = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 6);
            build_seq(op, fn, wf, wm);
            run_seq("random", op, fn);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_other_ops();
        test_illegal();
        test_timeout();
        test_reset_midwait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
